encoder_usb: RTL and testbench
==============================

# encoder_usb

Builds outgoing USB link frames. Takes a frame type, a payload length and a payload from a show-ahead FIFO, then emits the framed byte stream to the USB TX FIFO. Each frame is sync, header, header CRC8-ATM, payload and payload CRC8-ATM. It is the transmit counterpart of the receive frame decoder, and its frames are accepted unchanged by that decoder.

## Interface
Parameters:
- MAX_LEN, 57: largest payload in bytes, set by the 64-byte receive buffer minus 7 framing bytes.
- SYNC0, 8'h5E: frame byte 0.
- SYNC1, 8'h4D: frame byte 1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- n_rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to send a frame; sampled only in IDLE.
- type  in  8  frame type; captured on an accepted start.
- len  in  6  payload length, 0..MAX_LEN; captured on an accepted start.
- pl_d  in  8  payload byte at the head of the source FIFO (show-ahead).
- pl_empty  in  1  source FIFO empty.
- pl_rd  out  1  pop the source FIFO; asserted in the same cycle pl_d is loaded.
- q  out  8  frame byte to the USB TX FIFO (registered).
- q_valid  out  1  q holds a byte (registered).
- q_ready  in  1  TX FIFO not full; the byte transfers when q_valid & q_ready.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the final CRC byte transfers.
- err  out  1  one-cycle pulse when start is rejected because len > MAX_LEN.

## Operation
- Frame layout, with byte index i:
  - 0: SYNC0
  - 1: SYNC1
  - 2: type
  - 3: 8'h00 (length high)
  - 4: {2'b00,len}
  - 5: HCRC
  - 6..5+len: payload
  - 6+len: PCRC
- Total frame length is len+7 bytes.
- CRC8-ATM:
  - Polynomial x^8+x^2+x+1 (8'h07), init 8'h00, MSB first, no reflection, no final XOR.
  - The running CRC register updates with each byte loaded into the output register, for bytes 0–4 and all payload bytes.
  - HCRC is the CRC value after byte 4. The register is cleared to 0 when HCRC is loaded, so PCRC is the CRC over the payload only.
  - For len=0, PCRC is 8'h00.
  - The CRC over the whole frame is therefore 0.
- State machine:
  - IDLE → HDR on start with len ≤ MAX_LEN. A start with len > MAX_LEN pulses err and the block stays in IDLE.
  - HDR: loads bytes 0–4 using a 3-bit index, then → HCRC.
  - HCRC: loads HCRC, then → PAY, or → PCRC directly if len=0.
  - PAY: loads one payload byte per load opportunity while pl_empty=0, counting down a 6-bit remaining counter. When the counter reaches 0 after the last load → PCRC.
  - PCRC: loads PCRC, then → FIN.
  - FIN: waits until the final byte transfers, pulses done, → IDLE.
- Load opportunity: a cycle in which (~q_valid | q_ready). A byte is loaded only in such a cycle. In PAY a load also requires pl_empty=0.
- In PAY with pl_empty=1, nothing is loaded. q_valid drops once the held byte transfers; no bubble byte is ever emitted.
- While q_valid & ~q_ready, q is held stable and nothing loads. pl_rd is 0 in that cycle.
- start while busy is ignored and err is not pulsed.
- type and len are captured at start. Later changes on the type and len inputs have no effect on the frame in progress.

## Timing
- Reset values: q=8'h00, q_valid=0, pl_rd=0, busy=0, done=0, err=0, state IDLE, CRC register 8'h00.
- n_rst asserted mid-frame aborts immediately to the reset values. The partial frame is discarded with no done pulse.
- start sampled at edge N → busy=1 and q=SYNC0, q_valid=1 after edge N+1.
- With q_ready=1 and the source never empty, the block emits one byte per cycle. The frame occupies len+7 consecutive cycles.
- done is 1 in the cycle after the PCRC transfer. busy falls in the same cycle as done.
- A new start is accepted in the cycle done is high.
- err is asserted the cycle after the rejected start.
- pl_rd is combinational from state, pl_empty and the load opportunity. It never asserts outside PAY, and at most len times per frame.

## Test plan
- type=01, len=6, payload 01..06, q_ready=1: stream is 5E 4D 01 00 06 B4 01 02 03 04 05 06 2F over 13 cycles, done at cycle 14, pl_rd high exactly 6 cycles.
- Same frame with q_ready toggled pseudo-randomly: identical byte sequence, q stable while stalled, no duplicated or dropped bytes.
- len=0, type=01: stream is 5E 4D 01 00 00 HCRC 00 with HCRC=CRC8-ATM(5E 4D 01 00 00), 7 bytes total, pl_rd never asserted.
- len=57 with pl_empty holding 1 for 5 cycles mid-payload: 64 bytes emitted, q_valid low during the gap, and the CRC over all 64 bytes is 0.
- len=58: err pulses once, busy stays 0, q_valid stays 0. start during busy: ignored, current frame unaffected.
- n_rst pulsed after byte 8 of a len=6 frame: all outputs return to reset values with no done. A following start sends a complete, correct frame.

Source files
------------

// File: rtl/encoder_usb.sv
// encoder_usb
// Builds outgoing USB link frames: SYNC0, SYNC1, type, 8'h00, {2'b00,len},
// HCRC, payload bytes, PCRC. Both CRCs are CRC8-ATM (poly 8'h07, init 0,
// MSB first), so the CRC over a whole frame is 0.
//
// Ports:
//   clk, n_rst        clock, asynchronous active-low reset
//   start             one-cycle frame request, honoured only when idle
//   frame_type, len   frame type and payload length, captured on accepted start
//                     (the type input is frame_type because 'type' is reserved)
//   pl_d, pl_empty    head byte and empty flag of the show-ahead payload FIFO
//   pl_rd             pop of the payload FIFO, same cycle pl_d is loaded
//   q, q_valid        registered output byte and its valid flag
//   q_ready           downstream TX FIFO can accept q this cycle
//   busy              frame in progress
//   done              one-cycle pulse after the final CRC byte transfers
//   err               one-cycle pulse when a start with len > MAX_LEN is rejected
module encoder_usb #(
  parameter int unsigned MAX_LEN = 57,
  parameter logic [7:0]  SYNC0   = 8'h5E,
  parameter logic [7:0]  SYNC1   = 8'h4D
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic [7:0] frame_type,
  input  logic [5:0] len,
  input  logic [7:0] pl_d,
  input  logic       pl_empty,
  output logic       pl_rd,
  output logic [7:0] q,
  output logic       q_valid,
  input  logic       q_ready,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [5:0] MAX_LEN6 = 6'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_HCRC = 3'd2,
    S_PAY  = 3'd3,
    S_PCRC = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  // One byte step of CRC8-ATM, MSB first.
  function automatic logic [7:0] crc8_atm(input logic [7:0] crc_in, input logic [7:0] data);
    logic [7:0] c;
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) begin
        c = {c[6:0], 1'b0} ^ 8'h07;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

  state_t     state, state_n;
  logic [2:0] idx, idx_n;
  logic [5:0] rem, rem_n;
  logic [7:0] type_q, type_n;
  logic [5:0] len_q, len_n;
  logic [7:0] crc, crc_n;
  logic [7:0] hdr_byte;
  logic [7:0] load_byte;
  logic       load;
  logic       done_n;
  logic       err_n;
  logic       load_ok;
  logic       xfer;

  // A new byte may enter q when q is empty or its byte leaves this cycle.
  assign load_ok = ~q_valid | q_ready;
  assign xfer    = q_valid & q_ready;

  // Header byte selected by the header index.
  always_comb begin
    hdr_byte = 8'h00;
    case (idx)
      3'd0:    hdr_byte = SYNC0;
      3'd1:    hdr_byte = SYNC1;
      3'd2:    hdr_byte = type_q;
      3'd3:    hdr_byte = 8'h00;
      3'd4:    hdr_byte = {2'b00, len_q};
      default: hdr_byte = 8'h00;
    endcase
  end

  // Next-state, load selection and pulse generation.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    rem_n     = rem;
    type_n    = type_q;
    len_n     = len_q;
    crc_n     = crc;
    load      = 1'b0;
    load_byte = 8'h00;
    done_n    = 1'b0;
    err_n     = 1'b0;
    pl_rd     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (len > MAX_LEN6) begin
            err_n = 1'b1;
          end else begin
            state_n = S_HDR;
            idx_n   = 3'd0;
            type_n  = frame_type;
            len_n   = len;
            crc_n   = 8'h00;
          end
        end else begin
          state_n = S_IDLE;
        end
      end
      S_HDR: begin
        if (load_ok) begin
          load      = 1'b1;
          load_byte = hdr_byte;
          crc_n     = crc8_atm(crc, hdr_byte);
          if (idx == 3'd4) begin
            state_n = S_HCRC;
          end else begin
            idx_n = idx + 3'd1;
          end
        end else begin
          state_n = S_HDR;
        end
      end
      S_HCRC: begin
        if (load_ok) begin
          load      = 1'b1;
          load_byte = crc;
          // Restart the CRC so PCRC covers the payload alone.
          crc_n     = 8'h00;
          rem_n     = len_q;
          if (len_q == 6'd0) begin
            state_n = S_PCRC;
          end else begin
            state_n = S_PAY;
          end
        end else begin
          state_n = S_HCRC;
        end
      end
      S_PAY: begin
        if (load_ok && !pl_empty) begin
          load      = 1'b1;
          load_byte = pl_d;
          pl_rd     = 1'b1;
          crc_n     = crc8_atm(crc, pl_d);
          rem_n     = rem - 6'd1;
          if (rem <= 6'd1) begin
            state_n = S_PCRC;
          end else begin
            state_n = S_PAY;
          end
        end else begin
          state_n = S_PAY;
        end
      end
      S_PCRC: begin
        if (load_ok) begin
          load      = 1'b1;
          load_byte = crc;
          crc_n     = 8'h00;
          state_n   = S_FIN;
        end else begin
          state_n = S_PCRC;
        end
      end
      S_FIN: begin
        if (xfer) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else begin
          state_n = S_FIN;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State, captured frame fields, CRC and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= S_IDLE;
      idx     <= 3'd0;
      rem     <= 6'd0;
      type_q  <= 8'h00;
      len_q   <= 6'd0;
      crc     <= 8'h00;
      q       <= 8'h00;
      q_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      rem    <= rem_n;
      type_q <= type_n;
      len_q  <= len_n;
      crc    <= crc_n;
      if (load) begin
        q       <= load_byte;
        q_valid <= 1'b1;
      end else if (xfer) begin
        q_valid <= 1'b0;
      end else begin
        q_valid <= q_valid;
      end
      busy <= (state_n != S_IDLE);
      done <= done_n;
      err  <= err_n;
    end
  end

endmodule

// File: tb/tb_encoder_usb.sv
module tb_encoder_usb;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       start;
  logic [7:0] frame_type;
  logic [5:0] len;
  logic [7:0] pl_d;
  logic       pl_empty;
  logic       pl_rd;
  logic [7:0] q;
  logic       q_valid;
  logic       q_ready;
  logic       busy;
  logic       done;
  logic       err;

  int total = 0;
  int bad   = 0;

  encoder_usb #(.MAX_LEN(57), .SYNC0(8'h5E), .SYNC1(8'h4D)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .frame_type(frame_type), .len(len),
    .pl_d(pl_d), .pl_empty(pl_empty), .pl_rd(pl_rd), .q(q), .q_valid(q_valid),
    .q_ready(q_ready), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Show-ahead payload FIFO model.
  logic [7:0] src_mem [0:63];
  logic [6:0] src_len = 7'd0;
  logic [6:0] rd_ptr  = 7'd0;
  logic       pl_hold = 1'b0;
  logic       src_rst = 1'b0;
  assign pl_d     = src_mem[rd_ptr[5:0]];
  assign pl_empty = pl_hold | (rd_ptr >= src_len);
  always @(posedge clk) begin
    if (src_rst) rd_ptr <= 7'd0;
    else if (pl_rd) rd_ptr <= rd_ptr + 7'd1;
  end

  // Transfer monitor: collects bytes and counts pops, pulses, stall breaches.
  logic [7:0] got[$];
  int         prd_cnt = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         viol_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_q = 8'h00;
  logic       mon_clr = 1'b0;
  always @(negedge clk) begin
    if (mon_clr) begin
      got.delete();
      prd_cnt    <= 0;
      done_cnt   <= 0;
      err_cnt    <= 0;
      viol_cnt   <= 0;
      prev_stall <= 1'b0;
    end else begin
      if (q_valid && q_ready) got.push_back(q);
      if (pl_rd) prd_cnt <= prd_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (err) err_cnt <= err_cnt + 1;
      viol_cnt <= viol_cnt
                + ((n_rst && prev_stall && (!q_valid || q !== prev_q)) ? 1 : 0)
                + ((pl_rd && q_valid && !q_ready) ? 1 : 0);
      prev_stall <= n_rst && q_valid && !q_ready;
      prev_q     <= q;
    end
  end

  logic [7:0] exp_basic [0:12] = '{8'h5E, 8'h4D, 8'h01, 8'h00, 8'h06, 8'hB4,
                                   8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h2F};
  logic [7:0] exp_len0 [0:6]   = '{8'h5E, 8'h4D, 8'h01, 8'h00, 8'h00, 8'hA6, 8'h00};

  // Reference CRC8-ATM written as bitwise polynomial division.
  function automatic logic [7:0] ref_crc(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int b = 7; b >= 0; b--) begin
      fb = r[7] ^ d[b];
      r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  task automatic load_src(input int n, input logic [7:0] base);
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) src_mem[i] = 8'(base + i);
    src_len = 7'(n);
    src_rst = 1'b1;
    mon_clr = 1'b1;
    @(posedge clk); #1;
    src_rst = 1'b0;
    mon_clr = 1'b0;
  endtask

  task automatic send_start(input logic [7:0] t, input logic [5:0] l);
    frame_type = t;
    len        = l;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int c;
    c = 0;
    while (done_cnt == 0 && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    ok = (done_cnt != 0);
  endtask

  task automatic test_reset;
    n_rst = 1'b0; start = 1'b0; frame_type = 8'h00; len = 6'd0;
    q_ready = 1'b1; pl_hold = 1'b0; src_rst = 1'b1; mon_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (q !== 8'h00)     begin bad++; $display("FAIL reset_q got=%h want=00", q); end
    total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL reset_q_valid got=%b want=0", q_valid); end
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0)    begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (err !== 1'b0)     begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    total++; if (pl_rd !== 1'b0)   begin bad++; $display("FAIL reset_pl_rd got=%b want=0", pl_rd); end
    n_rst = 1'b1; src_rst = 1'b0; mon_clr = 1'b0;
  endtask

  task automatic test_basic;
    load_src(6, 8'h01);
    send_start(8'h01, 6'd6);
    frame_type = 8'hFF;  // later input changes must not affect the frame
    len        = 6'd3;
    @(negedge clk);
    total++; if (busy !== 1'b1 || q_valid !== 1'b0)
      begin bad++; $display("FAIL basic_lead busy=%b q_valid=%b want busy=1 q_valid=0", busy, q_valid); end
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      total++; if (q_valid !== 1'b1 || q !== exp_basic[i])
        begin bad++; $display("FAIL basic_byte%0d got=%h valid=%b want=%h", i, q, q_valid, exp_basic[i]); end
    end
    @(negedge clk);
    total++; if (done !== 1'b1 || busy !== 1'b0 || q_valid !== 1'b0)
      begin bad++; $display("FAIL basic_done done=%b busy=%b q_valid=%b want 1 0 0", done, busy, q_valid); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b want=0", done); end
    total++; if (prd_cnt !== 6) begin bad++; $display("FAIL basic_pl_rd_count got=%0d want=6", prd_cnt); end
  endtask

  task automatic test_stall;
    bit ok;
    int c;
    load_src(6, 8'h01);
    send_start(8'h01, 6'd6);
    c = 0;
    while (done_cnt == 0 && c < 400) begin
      @(posedge clk); #1;
      q_ready = 1'($urandom_range(0, 1));
      c++;
    end
    q_ready = 1'b1;
    ok = (done_cnt != 0);
    total++; if (!ok) begin bad++; $display("FAIL stall_timeout done_cnt=%0d want=1", done_cnt); end
    total++; if (got.size() !== 13) begin bad++; $display("FAIL stall_count got=%0d want=13", got.size()); end
    for (int i = 0; i < 13; i++) begin
      total++; if (i >= got.size() || got[i] !== exp_basic[i])
        begin bad++; $display("FAIL stall_byte%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 8'hxx, exp_basic[i]); end
    end
    total++; if (viol_cnt !== 0) begin bad++; $display("FAIL stall_hold violations=%0d want=0", viol_cnt); end
    total++; if (prd_cnt !== 6)  begin bad++; $display("FAIL stall_pl_rd_count got=%0d want=6", prd_cnt); end
  endtask

  task automatic test_len0;
    bit ok;
    load_src(0, 8'h00);
    send_start(8'h01, 6'd0);
    wait_done(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL len0_timeout done_cnt=%0d want=1", done_cnt); end
    total++; if (got.size() !== 7) begin bad++; $display("FAIL len0_count got=%0d want=7", got.size()); end
    for (int i = 0; i < 7; i++) begin
      total++; if (i >= got.size() || got[i] !== exp_len0[i])
        begin bad++; $display("FAIL len0_byte%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 8'hxx, exp_len0[i]); end
    end
    total++; if (prd_cnt !== 0) begin bad++; $display("FAIL len0_pl_rd got=%0d want=0", prd_cnt); end
  endtask

  task automatic test_len57_gap;
    bit ok;
    int c;
    logic [7:0] crc_all;
    logic [7:0] hdr [0:4];
    hdr[0] = 8'h5E; hdr[1] = 8'h4D; hdr[2] = 8'h22; hdr[3] = 8'h00; hdr[4] = 8'h39;
    load_src(57, 8'h10);
    send_start(8'h22, 6'd57);
    c = 0;
    while (got.size() < 30 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    total++; if (got.size() < 30) begin bad++; $display("FAIL max_gap_reach got=%0d want>=30", got.size()); end
    pl_hold = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (q_valid !== 1'b0 || busy !== 1'b1 || pl_rd !== 1'b0)
      begin bad++; $display("FAIL max_gap_idle q_valid=%b busy=%b pl_rd=%b want 0 1 0", q_valid, busy, pl_rd); end
    repeat (3) @(posedge clk);
    #1;
    pl_hold = 1'b0;
    wait_done(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL max_timeout done_cnt=%0d want=1", done_cnt); end
    total++; if (got.size() !== 64) begin bad++; $display("FAIL max_count got=%0d want=64", got.size()); end
    for (int i = 0; i < 5; i++) begin
      total++; if (i >= got.size() || got[i] !== hdr[i])
        begin bad++; $display("FAIL max_hdr%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 8'hxx, hdr[i]); end
    end
    for (int i = 0; i < 57; i++) begin
      total++; if (6 + i >= got.size() || got[6 + i] !== 8'(8'h10 + i))
        begin bad++; $display("FAIL max_pay%0d got=%h want=%h", i, (6 + i < got.size()) ? got[6 + i] : 8'hxx, 8'(8'h10 + i)); end
    end
    crc_all = 8'h00;
    foreach (got[i]) crc_all = ref_crc(crc_all, got[i]);
    total++; if (crc_all !== 8'h00) begin bad++; $display("FAIL max_frame_crc got=%h want=00", crc_all); end
    total++; if (prd_cnt !== 57) begin bad++; $display("FAIL max_pl_rd got=%0d want=57", prd_cnt); end
  endtask

  task automatic test_err;
    load_src(0, 8'h00);
    send_start(8'h01, 6'd58);
    total++; if (err !== 1'b1 || busy !== 1'b0 || q_valid !== 1'b0)
      begin bad++; $display("FAIL err_pulse err=%b busy=%b q_valid=%b want 1 0 0", err, busy, q_valid); end
    @(posedge clk); #1;
    total++; if (err !== 1'b0 || busy !== 1'b0 || q_valid !== 1'b0)
      begin bad++; $display("FAIL err_after err=%b busy=%b q_valid=%b want 0 0 0", err, busy, q_valid); end
    repeat (4) @(posedge clk);
    #1;
    total++; if (err_cnt !== 1 || got.size() !== 0)
      begin bad++; $display("FAIL err_once err_cnt=%0d bytes=%0d want 1 0", err_cnt, got.size()); end
  endtask

  task automatic test_start_busy;
    bit ok;
    load_src(6, 8'h01);
    send_start(8'h01, 6'd6);
    repeat (4) @(posedge clk);
    #1;
    send_start(8'hAA, 6'd2);
    repeat (2) @(posedge clk);
    #1;
    send_start(8'hBB, 6'd60);
    wait_done(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL busy_timeout done_cnt=%0d want=1", done_cnt); end
    total++; if (got.size() !== 13) begin bad++; $display("FAIL busy_count got=%0d want=13", got.size()); end
    for (int i = 0; i < 13; i++) begin
      total++; if (i >= got.size() || got[i] !== exp_basic[i])
        begin bad++; $display("FAIL busy_byte%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 8'hxx, exp_basic[i]); end
    end
    total++; if (err_cnt !== 0) begin bad++; $display("FAIL busy_no_err got=%0d want=0", err_cnt); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0 || done_cnt !== 1)
      begin bad++; $display("FAIL busy_idle busy=%b done_cnt=%0d want 0 1", busy, done_cnt); end
  endtask

  task automatic test_reset_abort;
    bit ok;
    int c;
    load_src(6, 8'h01);
    send_start(8'h01, 6'd6);
    c = 0;
    while (got.size() < 8 && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    total++; if (got.size() < 8) begin bad++; $display("FAIL abort_reach got=%0d want>=8", got.size()); end
    n_rst = 1'b0;
    #1;
    total++; if (q !== 8'h00 || q_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || pl_rd !== 1'b0)
      begin bad++; $display("FAIL abort_outputs q=%h v=%b busy=%b done=%b err=%b pl_rd=%b want 00 0 0 0 0 0", q, q_valid, busy, done, err, pl_rd); end
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (done_cnt !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", done_cnt); end
    load_src(6, 8'h01);
    send_start(8'h01, 6'd6);
    wait_done(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL abort_resend_timeout done_cnt=%0d want=1", done_cnt); end
    total++; if (got.size() !== 13) begin bad++; $display("FAIL abort_resend_count got=%0d want=13", got.size()); end
    for (int i = 0; i < 13; i++) begin
      total++; if (i >= got.size() || got[i] !== exp_basic[i])
        begin bad++; $display("FAIL abort_resend_byte%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 8'hxx, exp_basic[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_len0();
    test_len57_gap();
    test_err();
    test_start_busy();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
